regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Write-back arbiter for the RV32 register file's single write port (clk_i, reset_i, wen_i, rd_idx_i, rd_data_i).
- Two requesters compete for that port: the ALU writeback path and the load/store unit (LSU).
- Round-robin arbitration, one accepted write per cycle.
- One registered output stage drives the regfile write port. The stage can be frozen by a pipeline hold.
- Writes to x0 are consumed without touching the regfile.
- The pending write is exported so hazard logic can stall or forward.

Parameters:
XLEN, 32, data width of write-back values.
REG_IDX_W, 5, register index width (32 architectural registers).

Ports:
clk_i  in  1  clock; all state updates on rising edge.
reset_i  in  1  synchronous, active-high reset.
hold_i  in  1  pipeline freeze; blocks drain of output stage.
alu_valid_i  in  1  ALU write request.
alu_ready_o  out  1  ALU request accepted this cycle.
alu_rd_idx_i  in  REG_IDX_W  ALU destination register.
alu_rd_data_i  in  XLEN  ALU result.
lsu_valid_i  in  1  LSU write request.
lsu_ready_o  out  1  LSU request accepted this cycle.
lsu_rd_idx_i  in  REG_IDX_W  LSU destination register.
lsu_rd_data_i  in  XLEN  load data.
rf_wen_o  out  1  to regfile wen_i.
rf_rd_idx_o  out  REG_IDX_W  to regfile rd_idx_i.
rf_rd_data_o  out  XLEN  to regfile rd_data_i.
pend_vld_o  out  1  output stage holds an unretired write.
pend_idx_o  out  REG_IDX_W  destination index of that write.

Behaviour:
Reset (reset_i high at an edge):
- out_vld=0, rf_rd_idx_o=0, rf_rd_data_o=0, last_grant=LSU, so the ALU wins the first conflict.
- While reset_i is high, alu_ready_o=lsu_ready_o=0 and rf_wen_o=0.
- Reset mid-operation discards any held write; it is never written.

Output stage:
- Register {out_vld, idx, data}.
- rf_wen_o = out_vld & ~hold_i (combinational). The stage drains in every cycle that rf_wen_o=1.

Accept condition:
- accept_ok = ~reset_i & (~out_vld | ~hold_i).
- A full stage under hold blocks new grants.
- An empty stage under hold still accepts one write.

Grant, combinational, only when accept_ok:
- Only ALU valid: ALU granted.
- Only LSU valid: LSU granted.
- Both valid: the requester other than last_grant is granted.
- Exactly one ready_o is high per grant. ready_o never asserts without its valid_i.
- Handshake completes when valid & ready. Requesters hold idx/data stable while valid & ~ready.

On a grant edge:
- last_grant updates to the granted source.
- idx/data are loaded into the output stage.
- out_vld = (granted idx != 0): an x0 write is accepted but dropped.
- With no grant, if the stage drained then out_vld <- 0; otherwise the stage holds its value.

Latency:
- Request accepted at edge N gives rf_wen_o=1 during cycle N+1 (if hold_i=0).
- Regfile updated at edge N+1.

Simultaneous writes to the same rd:
- Serialised in grant order. The later grant's data is the final register value.

pend_vld_o = out_vld and pend_idx_o = stage idx, both registered. hold_i does not mask them.

Decomposition:
- Shared package: REG_IDX_W/XLEN defaults, a source-ID encoding (SRC_ALU=0, SRC_LSU=1), and a REG_ZERO=0 constant.
- Natural sub-module: rr_arbiter2, a two-way round-robin grant plus last_grant state. It is reusable for other two-requester resources.
- Output stage and x0 filter remain in the top.

Test Plan:
- Reset, then alu_valid=1 idx=3 data=0x1337 for one cycle → alu_ready=1 that cycle; next cycle rf_wen=1, rf_rd_idx=3, rf_rd_data=0x1337, pend_vld=1, pend_idx=3; regfile rs1 idx 3 reads 0x1337 afterwards.
- Both valid for 4 cycles (ALU idx5 0xA, LSU idx6 0xB) → grants alternate ALU, LSU, ALU, LSU (ALU first after reset); rf_wen high each following cycle with the matching idx/data.
- LSU idx 0 data 0xFFFF → lsu_ready=1; next cycle rf_wen=0, pend_vld=0; regfile x0 still reads 0.
- Write idx7 0x55 accepted, then hold_i=1 for 3 cycles with ALU valid idx8 → rf_wen=0 and alu_ready=0 during hold, pend_idx=7; on hold release rf_wen=1 for idx7 with alu_ready=1 the same cycle; idx8 written the next cycle.
- ALU idx4 0x1 and LSU idx4 0x2 both valid, last_grant=ALU → LSU granted first, then ALU; final regfile x4 = 0x1.
- Write accepted, reset_i asserted the following cycle → rf_wen=0, pend_vld=0; the target register retains its old value.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared constants and source encoding for the regfile write-back arbiter
package regfile_wb_arbiter_pkg;

    localparam int XLEN_DEF      = 32;
    localparam int REG_IDX_W_DEF = 5;
    localparam int unsigned REG_ZERO = 0;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

endpackage

// File: rtl/regfile_wb_arbiter_arb.sv
// rtl/regfile_wb_arbiter_arb.sv - two-way round-robin grant with last-grant state
module rr_arbiter2
    import regfile_wb_arbiter_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    src_e last_q, last_d;

    // On a conflict the requester that did not win last time goes first.
    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = (last_q == SRC_LSU) ? 2'b01 : 2'b10;
                default: gnt_o = 2'b00;
            endcase
        end
    end

    always_comb begin
        last_d = last_q;
        if (gnt_o[SRC_ALU])
            last_d = SRC_ALU;
        else if (gnt_o[SRC_LSU])
            last_d = SRC_LSU;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i)
            last_q <= SRC_LSU;
        else
            last_q <= last_d;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - ALU/LSU write-back arbiter feeding the regfile write port
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int REG_IDX_W = REG_IDX_W_DEF
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 hold_i,
    input  logic                 alu_valid_i,
    output logic                 alu_ready_o,
    input  logic [REG_IDX_W-1:0] alu_rd_idx_i,
    input  logic [XLEN-1:0]      alu_rd_data_i,
    input  logic                 lsu_valid_i,
    output logic                 lsu_ready_o,
    input  logic [REG_IDX_W-1:0] lsu_rd_idx_i,
    input  logic [XLEN-1:0]      lsu_rd_data_i,
    output logic                 rf_wen_o,
    output logic [REG_IDX_W-1:0] rf_rd_idx_o,
    output logic [XLEN-1:0]      rf_rd_data_o,
    output logic                 pend_vld_o,
    output logic [REG_IDX_W-1:0] pend_idx_o
);

    logic                 out_vld_q, out_vld_d;
    logic [REG_IDX_W-1:0] out_idx_q, out_idx_d;
    logic [XLEN-1:0]      out_data_q, out_data_d;
    logic                 accept_ok;
    logic [1:0]           gnt;
    logic [REG_IDX_W-1:0] sel_idx;
    logic [XLEN-1:0]      sel_data;

    assign rf_wen_o  = out_vld_q & ~hold_i & ~reset_i;
    // An empty stage may still take one write while the pipeline is held.
    assign accept_ok = ~reset_i & (~out_vld_q | ~hold_i);

    rr_arbiter2 u_arb (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (accept_ok),
        .req_i   ({lsu_valid_i, alu_valid_i}),
        .gnt_o   (gnt)
    );

    assign alu_ready_o = gnt[SRC_ALU];
    assign lsu_ready_o = gnt[SRC_LSU];
    assign sel_idx     = gnt[SRC_LSU] ? lsu_rd_idx_i  : alu_rd_idx_i;
    assign sel_data    = gnt[SRC_LSU] ? lsu_rd_data_i : alu_rd_data_i;

    always_comb begin
        out_vld_d  = out_vld_q;
        out_idx_d  = out_idx_q;
        out_data_d = out_data_q;
        if (|gnt) begin
            out_vld_d  = (sel_idx != REG_IDX_W'(REG_ZERO));
            out_idx_d  = sel_idx;
            out_data_d = sel_data;
        end else if (rf_wen_o) begin
            out_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            out_vld_q  <= 1'b0;
            out_idx_q  <= '0;
            out_data_q <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_idx_q  <= out_idx_d;
            out_data_q <= out_data_d;
        end
    end

    assign rf_rd_idx_o  = out_idx_q;
    assign rf_rd_data_o = out_data_q;
    assign pend_vld_o   = out_vld_q;
    assign pend_idx_o   = out_idx_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - table-driven check of the write-back arbiter
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset_i, hold_i;
    logic        alu_valid_i, alu_ready_o, lsu_valid_i, lsu_ready_o;
    logic [4:0]  alu_rd_idx_i, lsu_rd_idx_i, rf_rd_idx_o, pend_idx_o;
    logic [31:0] alu_rd_data_i, lsu_rd_data_i, rf_rd_data_o;
    logic        rf_wen_o, pend_vld_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rf_model [32];

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .hold_i        (hold_i),
        .alu_valid_i   (alu_valid_i),
        .alu_ready_o   (alu_ready_o),
        .alu_rd_idx_i  (alu_rd_idx_i),
        .alu_rd_data_i (alu_rd_data_i),
        .lsu_valid_i   (lsu_valid_i),
        .lsu_ready_o   (lsu_ready_o),
        .lsu_rd_idx_i  (lsu_rd_idx_i),
        .lsu_rd_data_i (lsu_rd_data_i),
        .rf_wen_o      (rf_wen_o),
        .rf_rd_idx_o   (rf_rd_idx_o),
        .rf_rd_data_o  (rf_rd_data_o),
        .pend_vld_o    (pend_vld_o),
        .pend_idx_o    (pend_idx_o)
    );

    // Behavioural register file on the write port; x0 is left writable so a stray write shows up.
    always @(posedge clk) begin
        if (rf_wen_o)
            rf_model[rf_rd_idx_o] <= rf_rd_data_o;
    end

    typedef struct {
        logic        rst, hold;
        logic        av;  logic [4:0] ai; logic [31:0] ad;
        logic        lv;  logic [4:0] li; logic [31:0] ld;
        logic        ar, lr, wen;
        logic [4:0]  ridx; logic [31:0] rdata;
        logic        pv;  logic [4:0] pi;
    } vec_t;

    vec_t vecs [25];

    function automatic vec_t mk(logic rst, logic hold,
                                logic av, logic [4:0] ai, logic [31:0] ad,
                                logic lv, logic [4:0] li, logic [31:0] ld,
                                logic ar, logic lr, logic wen,
                                logic [4:0] ridx, logic [31:0] rdata,
                                logic pv, logic [4:0] pi);
        vec_t v;
        v.rst = rst; v.hold = hold;
        v.av = av; v.ai = ai; v.ad = ad;
        v.lv = lv; v.li = li; v.ld = ld;
        v.ar = ar; v.lr = lr; v.wen = wen;
        v.ridx = ridx; v.rdata = rdata; v.pv = pv; v.pi = pi;
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++)
            rf_model[i] = (i == 0) ? 32'h0 : (32'hC0DE_0000 | 32'(i));

        //               rst hold av ai  ad          lv li  ld          ar lr wen ridx rdata      pv pi
        vecs[0]  = mk(0, 0, 1, 3,  32'h1337, 0, 0,  32'h0,     1, 0, 0, 0,  32'h0,    0, 0);
        vecs[1]  = mk(0, 0, 0, 0,  32'h0,    0, 0,  32'h0,     0, 0, 1, 3,  32'h1337, 1, 3);
        vecs[2]  = mk(1, 0, 1, 5,  32'hA,    1, 6,  32'hB,     0, 0, 0, 3,  32'h1337, 0, 3);
        vecs[3]  = mk(0, 0, 1, 5,  32'hA,    1, 6,  32'hB,     1, 0, 0, 0,  32'h0,    0, 0);
        vecs[4]  = mk(0, 0, 1, 5,  32'hA,    1, 6,  32'hB,     0, 1, 1, 5,  32'hA,    1, 5);
        vecs[5]  = mk(0, 0, 1, 5,  32'hA,    1, 6,  32'hB,     1, 0, 1, 6,  32'hB,    1, 6);
        vecs[6]  = mk(0, 0, 1, 5,  32'hA,    1, 6,  32'hB,     0, 1, 1, 5,  32'hA,    1, 5);
        vecs[7]  = mk(0, 0, 0, 0,  32'h0,    0, 0,  32'h0,     0, 0, 1, 6,  32'hB,    1, 6);
        vecs[8]  = mk(0, 0, 0, 0,  32'h0,    1, 0,  32'hFFFF,  0, 1, 0, 6,  32'hB,    0, 6);
        vecs[9]  = mk(0, 0, 0, 0,  32'h0,    0, 0,  32'h0,     0, 0, 0, 0,  32'hFFFF, 0, 0);
        vecs[10] = mk(0, 0, 1, 7,  32'h55,   0, 0,  32'h0,     1, 0, 0, 0,  32'hFFFF, 0, 0);
        vecs[11] = mk(0, 1, 1, 8,  32'h88,   0, 0,  32'h0,     0, 0, 0, 7,  32'h55,   1, 7);
        vecs[12] = mk(0, 1, 1, 8,  32'h88,   0, 0,  32'h0,     0, 0, 0, 7,  32'h55,   1, 7);
        vecs[13] = mk(0, 1, 1, 8,  32'h88,   0, 0,  32'h0,     0, 0, 0, 7,  32'h55,   1, 7);
        vecs[14] = mk(0, 0, 1, 8,  32'h88,   0, 0,  32'h0,     1, 0, 1, 7,  32'h55,   1, 7);
        vecs[15] = mk(0, 0, 0, 0,  32'h0,    0, 0,  32'h0,     0, 0, 1, 8,  32'h88,   1, 8);
        vecs[16] = mk(0, 0, 1, 4,  32'h1,    1, 4,  32'h2,     0, 1, 0, 8,  32'h88,   0, 8);
        vecs[17] = mk(0, 0, 1, 4,  32'h1,    0, 0,  32'h0,     1, 0, 1, 4,  32'h2,    1, 4);
        vecs[18] = mk(0, 0, 0, 0,  32'h0,    0, 0,  32'h0,     0, 0, 1, 4,  32'h1,    1, 4);
        vecs[19] = mk(0, 1, 1, 9,  32'h99,   0, 0,  32'h0,     1, 0, 0, 4,  32'h1,    0, 4);
        vecs[20] = mk(0, 1, 0, 0,  32'h0,    0, 0,  32'h0,     0, 0, 0, 9,  32'h99,   1, 9);
        vecs[21] = mk(0, 0, 0, 0,  32'h0,    0, 0,  32'h0,     0, 0, 1, 9,  32'h99,   1, 9);
        vecs[22] = mk(0, 0, 1, 10, 32'hAA,   0, 0,  32'h0,     1, 0, 0, 9,  32'h99,   0, 9);
        vecs[23] = mk(1, 0, 0, 0,  32'h0,    0, 0,  32'h0,     0, 0, 0, 10, 32'hAA,   1, 10);
        vecs[24] = mk(0, 0, 0, 0,  32'h0,    0, 0,  32'h0,     0, 0, 0, 0,  32'h0,    0, 0);

        reset_i = 1'b1; hold_i = 1'b0;
        alu_valid_i = 1'b1; alu_rd_idx_i = 5'd2; alu_rd_data_i = 32'h2222;
        lsu_valid_i = 1'b1; lsu_rd_idx_i = 5'd1; lsu_rd_data_i = 32'h1111;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_alu_ready", -1, 32'(alu_ready_o), 32'h0);
        chk("rst_lsu_ready", -1, 32'(lsu_ready_o), 32'h0);
        chk("rst_rf_wen",    -1, 32'(rf_wen_o),    32'h0);
        chk("rst_pend_vld",  -1, 32'(pend_vld_o),  32'h0);
        chk("rst_rf_idx",    -1, 32'(rf_rd_idx_o), 32'h0);
        chk("rst_rf_data",   -1, rf_rd_data_o,     32'h0);
        @(negedge clk);

        for (int r = 0; r < 25; r++) begin
            reset_i       = vecs[r].rst;
            hold_i        = vecs[r].hold;
            alu_valid_i   = vecs[r].av;
            alu_rd_idx_i  = vecs[r].ai;
            alu_rd_data_i = vecs[r].ad;
            lsu_valid_i   = vecs[r].lv;
            lsu_rd_idx_i  = vecs[r].li;
            lsu_rd_data_i = vecs[r].ld;
            #1;
            chk("alu_ready", r, 32'(alu_ready_o), 32'(vecs[r].ar));
            chk("lsu_ready", r, 32'(lsu_ready_o), 32'(vecs[r].lr));
            chk("rf_wen",    r, 32'(rf_wen_o),    32'(vecs[r].wen));
            chk("rf_rd_idx", r, 32'(rf_rd_idx_o), 32'(vecs[r].ridx));
            chk("rf_rd_data", r, rf_rd_data_o,    vecs[r].rdata);
            chk("pend_vld",  r, 32'(pend_vld_o),  32'(vecs[r].pv));
            chk("pend_idx",  r, 32'(pend_idx_o),  32'(vecs[r].pi));
            @(negedge clk);
        end

        chk("rf_x0",  100, rf_model[0],  32'h0);
        chk("rf_x3",  100, rf_model[3],  32'h1337);
        chk("rf_x4",  100, rf_model[4],  32'h1);
        chk("rf_x5",  100, rf_model[5],  32'hA);
        chk("rf_x6",  100, rf_model[6],  32'hB);
        chk("rf_x7",  100, rf_model[7],  32'h55);
        chk("rf_x8",  100, rf_model[8],  32'h88);
        chk("rf_x9",  100, rf_model[9],  32'h99);
        chk("rf_x10", 100, rf_model[10], 32'hC0DE_000A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
